// File: rtl/spi_master_tx_pkg.sv
// spi_master_tx_pkg: FSM state encodings and SPI mode constants shared by the SPI master and its bench.
package spi_master_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    // Modes are {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK divider and edge counter; a tick ends every CLK_DIV-cycle slot while run is high.
// The first 2*DATA_WIDTH ticks are SCLK edges; last_edge flags the two ticks closing the final half-period and the trail.
module spi_sclk_gen #(
    parameter int   DATA_WIDTH = 8,
    parameter int   CLK_DIV    = 4,
    parameter logic CPOL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic lead_pulse,
    output logic trail_pulse,
    output logic last_edge
);

    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW  = $clog2(2 * DATA_WIDTH + 2);
    localparam logic [DVW-1:0] DIV_MAX = DVW'(CLK_DIV - 1);
    localparam logic [EW-1:0]  EDGES   = EW'(2 * DATA_WIDTH);
    localparam logic [EW-1:0]  E_END   = EW'(2 * DATA_WIDTH + 1);

    logic [DVW-1:0] div_q, div_d;
    logic [EW-1:0]  edge_q, edge_d;
    logic           sclk_q, sclk_d;
    logic           tick, toggle;

    always_comb begin
        tick        = run && (div_q == DIV_MAX);
        toggle      = tick && (edge_q < EDGES);
        div_d       = (!run || tick) ? '0 : div_q + 1'b1;
        edge_d      = (!run || (tick && edge_q == E_END)) ? '0 : edge_q + EW'(tick);
        sclk_d      = !run ? CPOL : sclk_q ^ toggle;
        lead_pulse  = toggle && !edge_q[0];
        trail_pulse = toggle && edge_q[0];
        last_edge   = tick && !toggle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= CPOL;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: single-lane SPI master, MSB-first word shift out on MOSI with parallel capture of MISO.
// FSM IDLE->LEAD->XFER->TRAIL; SCLK timing comes from spi_sclk_gen, all pad outputs registered.
module spi_master_tx
    import spi_master_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   CLK_DIV    = 4,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BITS_MAX = BW'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic                  cs_n_q, cs_n_d, mosi_q, mosi_d, done_q, done_d;
    logic                  lead_p, trail_p, end_p;
    logic                  accept, finish, sample, shift;

    spi_sclk_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .CLK_DIV   (CLK_DIV),
        .CPOL      (CPOL)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (state_q != IDLE),
        .sclk       (sclk),
        .lead_pulse (lead_p),
        .trail_pulse(trail_p),
        .last_edge  (end_p)
    );

    // bits_q counts captured bits; it gates MOSI so it only advances between samples
    always_comb begin
        accept    = (state_q == IDLE) && start;
        finish    = (state_q == TRAIL) && end_p;
        sample    = CPHA ? trail_p : lead_p;
        shift     = CPHA ? (lead_p && bits_q != '0) : (trail_p && bits_q != BITS_MAX);
        state_d   = accept                        ? LEAD  :
                    (state_q == LEAD && lead_p)   ? XFER  :
                    (state_q == XFER && end_p)    ? TRAIL :
                    finish                        ? IDLE  : state_q;
        tx_d      = accept ? tx_data : shift ? tx_q << 1 : tx_q;
        rx_d      = accept ? '0 : sample ? {rx_q[DATA_WIDTH-2:0], miso} : rx_q;
        bits_d    = accept ? '0 : bits_q + BW'(sample);
        mosi_d    = accept ? tx_data[DATA_WIDTH-1] : finish ? 1'b0 : shift ? tx_q[DATA_WIDTH-2] : mosi_q;
        cs_n_d    = (state_d == IDLE);
        done_d    = finish;
        rx_data_d = finish ? rx_q : rx_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            bits_q    <= '0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            bits_q    <= bits_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule
